// File: rtl/iter_alu.sv
// Handshaked ALU: single-cycle arithmetic/logic/shift/compare plus
// iterative shift-add multiply and restoring divide.
module iter_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  input  logic             carry_in,
  input  logic             shift_dir,
  input  logic             shift_type,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             CARRY,
  output logic             LT,
  output logic             GT,
  output logic             EQ,
  output logic             DIV_ZERO
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;
  localparam logic [3:0] OP_SHF = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_DIV = 4'd10;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_dif;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             res_c;
  logic             res_lt;
  logic             res_gt;
  logic             res_eq;
  logic             res_dz;
  logic             go_exec;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_dif;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;

  assign in_ready = (state == IDLE);

  assign add_sum = {1'b0, input_A} + {1'b0, input_B}
                 + {{WIDTH{1'b0}}, (op == OP_ADC) && carry_in};
  assign sub_dif = {1'b0, input_A} - {1'b0, input_B};

  always_comb begin
    res_lo  = '0;
    res_hi  = '0;
    res_c   = 1'b0;
    res_lt  = 1'b0;
    res_gt  = 1'b0;
    res_eq  = 1'b0;
    res_dz  = 1'b0;
    go_exec = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        res_lo = add_sum[WIDTH-1:0];
        res_c  = add_sum[WIDTH];
      end
      OP_SUB: begin
        res_lo = sub_dif[WIDTH-1:0];
        res_c  = sub_dif[WIDTH];
      end
      OP_AND: res_lo = input_A & input_B;
      OP_OR:  res_lo = input_A | input_B;
      OP_XOR: res_lo = input_A ^ input_B;
      OP_MOV: res_lo = input_B;
      OP_CMP: begin
        res_lt = input_A < input_B;
        res_gt = input_A > input_B;
        res_eq = input_A == input_B;
      end
      OP_SHF: begin
        if (shift_dir) begin
          res_lo = {shift_type & input_A[WIDTH-1], input_A[WIDTH-1:1]};
          res_c  = input_A[0];
        end else begin
          res_lo = {input_A[WIDTH-2:0], carry_in};
          res_c  = input_A[WIDTH-1];
        end
      end
      OP_MUL: go_exec = 1'b1;
      OP_DIV: begin
        if (input_B == '0) begin
          res_lo = '1;
          res_hi = input_A;
          res_dz = 1'b1;
        end else begin
          go_exec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // hi:lo is the product accumulator for MUL, remainder:quotient for DIV
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_reg} : '0);
  assign div_sh  = {hi, lo[WIDTH-1]};
  assign div_dif = div_sh - {1'b0, b_reg};

  always_comb begin
    hi_nxt = mul_sum[WIDTH:1];
    lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      if (!div_dif[WIDTH]) begin
        hi_nxt = div_dif[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = div_sh[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      is_div    <= 1'b0;
      b_reg     <= '0;
      hi        <= '0;
      lo        <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      out_hi    <= '0;
      CARRY     <= 1'b0;
      LT        <= 1'b0;
      GT        <= 1'b0;
      EQ        <= 1'b0;
      DIV_ZERO  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (go_exec) begin
              state  <= EXEC;
              cnt    <= '0;
              is_div <= (op == OP_DIV);
              b_reg  <= input_B;
              hi     <= '0;
              lo     <= input_A;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              out       <= res_lo;
              out_hi    <= res_hi;
              CARRY     <= res_c;
              LT        <= res_lt;
              GT        <= res_gt;
              EQ        <= res_eq;
              DIV_ZERO  <= res_dz;
            end
          end
        end
        EXEC: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            cnt       <= '0;
            out_valid <= 1'b1;
            out       <= lo_nxt;
            out_hi    <= hi_nxt;
            CARRY     <= !is_div && (hi_nxt != '0);
            LT        <= 1'b0;
            GT        <= 1'b0;
            EQ        <= 1'b0;
            DIV_ZERO  <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu at WIDTH=8.
// Flags are compared packed as {CARRY,LT,GT,EQ,DIV_ZERO}.
module tb_iter_alu;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] input_A;
  logic [7:0] input_B;
  logic       carry_in;
  logic       shift_dir;
  logic       shift_type;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic [7:0] out_hi;
  logic       CARRY;
  logic       LT;
  logic       GT;
  logic       EQ;
  logic       DIV_ZERO;

  int n_cmp = 0;
  int n_bad = 0;

  iter_alu #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .input_A(input_A), .input_B(input_B),
    .carry_in(carry_in), .shift_dir(shift_dir),
    .shift_type(shift_type),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_hi(out_hi),
    .CARRY(CARRY), .LT(LT), .GT(GT), .EQ(EQ),
    .DIV_ZERO(DIV_ZERO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {CARRY, LT, GT, EQ, DIV_ZERO};
  endfunction

  task automatic issue(input logic [3:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic ci,
                       input logic dir, input logic typ);
    @(negedge clk);
    op = o; input_A = a; input_B = b;
    carry_in = ci; shift_dir = dir; shift_type = typ;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic [3:0] o,
                     input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic dir,
                     input logic typ, input int lat,
                     input logic [7:0] eo, input logic [7:0] eh,
                     input logic [4:0] ef);
    int  n;
    bit  busy_ok;
    n = 1;
    busy_ok = 1'b1;
    issue(o, a, b, ci, dir, typ);
    while (!out_valid && n < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1 n++;
    end
    check({tag, ".lat"}, n, lat);
    check({tag, ".busy"}, busy_ok, 1);
    check({tag, ".out"}, out, eo);
    check({tag, ".hi"}, out_hi, eh);
    check({tag, ".flg"}, flags(), ef);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, ".rdy"}, in_ready, 1);
  endtask

  initial begin
    logic [7:0] h_out;
    logic [4:0] h_flg;
    bit         stable;
    bit         stale;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; input_A = '0; input_B = '0;
    carry_in = 1'b0; shift_dir = 1'b0; shift_type = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", out_valid, 0);
    check("rst.ready", in_ready, 1);
    check("rst.out", {out_hi, out}, 0);
    check("rst.flg", flags(), 0);
    @(negedge clk) reset = 1'b0;
    #1 check("rel.ready", in_ready, 1);

    run("add", 4'd0, 8'hF0, 8'h20, 0, 0, 0, 1, 8'h10, 8'h00, 5'b10000);
    run("adc", 4'd1, 8'h7F, 8'h80, 1, 0, 0, 1, 8'h00, 8'h00, 5'b10000);
    run("and", 4'd3, 8'hCC, 8'hAA, 0, 0, 0, 1, 8'h88, 8'h00, 5'b00000);
    run("or",  4'd4, 8'hCC, 8'hAA, 0, 0, 0, 1, 8'hEE, 8'h00, 5'b00000);
    run("xor", 4'd5, 8'hCC, 8'hAA, 0, 0, 0, 1, 8'h66, 8'h00, 5'b00000);
    run("mov", 4'd6, 8'hCC, 8'hAA, 0, 0, 0, 1, 8'hAA, 8'h00, 5'b00000);
    run("cmplt", 4'd7, 8'h05, 8'h07, 0, 0, 0, 1, 8'h00, 8'h00, 5'b01000);
    run("cmpeq", 4'd7, 8'h09, 8'h09, 0, 0, 0, 1, 8'h00, 8'h00, 5'b00010);
    run("cmpgt", 4'd7, 8'hFF, 8'h01, 0, 0, 0, 1, 8'h00, 8'h00, 5'b00100);
    run("sra", 4'd8, 8'h81, 8'h00, 0, 1, 1, 1, 8'hC0, 8'h00, 5'b10000);
    run("srl", 4'd8, 8'h81, 8'h00, 0, 1, 0, 1, 8'h40, 8'h00, 5'b10000);
    run("sl1", 4'd8, 8'h81, 8'h00, 1, 0, 0, 1, 8'h03, 8'h00, 5'b10000);
    run("sl0", 4'd8, 8'h40, 8'h00, 0, 0, 0, 1, 8'h80, 8'h00, 5'b00000);
    run("mul1", 4'd9, 8'd200, 8'd3, 0, 0, 0, 9, 8'h58, 8'h02, 5'b10000);
    run("mul2", 4'd9, 8'd15, 8'd17, 0, 0, 0, 9, 8'hFF, 8'h00, 5'b00000);
    run("mul3", 4'd9, 8'hFF, 8'hFF, 0, 0, 0, 9, 8'h01, 8'hFE, 5'b10000);
    run("div1", 4'd10, 8'd100, 8'd7, 0, 0, 0, 9, 8'h0E, 8'h02, 5'b00000);
    run("div2", 4'd10, 8'hFF, 8'h10, 0, 0, 0, 9, 8'h0F, 8'h0F, 5'b00000);
    run("div3", 4'd10, 8'd3, 8'd200, 0, 0, 0, 9, 8'h00, 8'h03, 5'b00000);
    run("div0", 4'd10, 8'h2A, 8'h00, 0, 0, 0, 1, 8'hFF, 8'h2A, 5'b00001);
    run("ill", 4'd12, 8'hFF, 8'hFF, 1, 1, 1, 1, 8'h00, 8'h00, 5'b00000);

    // backpressure: result must hold while new requests are offered
    issue(4'd2, 8'h05, 8'h07, 0, 0, 0);
    check("bp.valid", out_valid, 1);
    check("bp.out", out, 8'hFE);
    check("bp.flg", flags(), 5'b10000);
    h_out = out;
    h_flg = flags();
    stable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1; op = 4'd0; input_A = 8'h11; input_B = 8'h22;
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || out !== h_out || flags() !== h_flg)
        stable = 1'b0;
    end
    check("bp.stable", stable, 1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp.idle", in_ready, 1);
    check("bp.drop", out_valid, 0);

    // reset in the 4th EXEC cycle of a multiply
    issue(4'd9, 8'd200, 8'd3, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mr.valid", out_valid, 0);
    check("mr.ready", in_ready, 1);
    check("mr.out", {out_hi, out}, 0);
    @(negedge clk) reset = 1'b0;
    #1 check("mr.rel", in_ready, 1);
    stale = 1'b0;
    repeat (14) begin
      @(posedge clk);
      #1 if (out_valid) stale = 1'b1;
    end
    check("mr.stale", stale, 0);

    run("post", 4'd0, 8'h01, 8'h02, 0, 0, 0, 1, 8'h03, 8'h00, 5'b00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
